cv32e40s_clic_irq_arbiter: RTL
==============================

// Module: cv32e40s_clic_irq_arbiter
// PURPOSE
// - Core-local CLIC arbiter for NUM_IRQ interrupt lines. Holds per-source cfg (ie/ip/trig/shv/level).
// - Captures level- or rising-edge-triggered pending state; picks the highest-level pending-and-enabled source.
// - Filters the winner against mintstatus/mintthresh/mstatus, drives the controller's irq_* inputs.
// - Retires edge-pending state on the controller's take handshake. Replaces the external-CLIC front end.
// PARAMETERS
// - NUM_IRQ            32  number of interrupt sources (2..1024)
// - SMCLIC_ID_WIDTH     5  id width; must equal $clog2(NUM_IRQ)
// - CLIC_LEVEL_BITS     8  implemented level MSBs (1..8); unimplemented LSBs read as 1
// PORTS
// - clk                  in   1        clock
// - rst                  in   1        reset, synchronous, active-high
// - irq_i                in   NUM_IRQ  raw interrupt lines, synchronous to clk
// - cfg_we_i             in   1        write cfg of source cfg_id_i
// - cfg_id_i             in   ID_W     target source of cfg write
// - cfg_i                in   clic_irq_cfg_t  {ie, ip, trig, shv, level}
// - cfg_o                out  clic_irq_cfg_t  cfg of source cfg_id_i (combinational readback)
// - irq_ack_i            in   1        controller takes interrupt irq_id_ctrl_o this cycle
// - mstatus_i            in   mstatus_t     current mstatus (mie used)
// - mintthresh_i         in   8        interrupt threshold
// - mintstatus_i         in   mintstatus_t  current mil
// - mcause_i             in   mcause_t      mpil used for mnxti
// - priv_lvl_i           in   privlvl_t     current privilege
// - irq_req_ctrl_o       out  1        take-interrupt request
// - irq_id_ctrl_o        out  10       winner id, zero-extended
// - irq_wu_ctrl_o        out  1        wake-up request
// - irq_clic_shv_o       out  1        winner is selectively vectored
// - irq_clic_level_o     out  8        winner level
// - mnxti_irq_pending_o  out  1        non-shv winner available to mnxti
// - mnxti_irq_id_o       out  ID_W     winner id for mnxti
// - mnxti_irq_level_o    out  8        winner level for mnxti
// BEHAVIOUR
// - Reset: all cfg fields, irq_q, candidate regs and FSM cleared (FSM -> ARB); every output 0.
// - Level write: stored level = {cfg_i.level[7 -: LB], {8-LB{1'b1}}}; readback returns stored value.
// - ip, trig=LEVEL: ip <= irq_i[i] each cycle; cfg/ack writes to ip are ignored.
// - ip, trig=EDGE: set on irq_i[i] & ~irq_q[i]; clear on ack of i or cfg write ip=0.
//   Priority: edge set > cfg write > ack clear.
// - Arbitration: among ip&ie, max level; tie -> higher id. Level-0 sources never win.
//   Registered into cand_{vld,id,level,shv}_q. Latency: irq_i rise at edge N -> ip at N+1 -> cand at N+2.
// - irq_req_ctrl_o = cand_vld_q & state==ARB & (mstatus.mie | priv<M) &
//   (priv==M ? cand_level_q > max(mil,mintthresh) : cand_level_q > 0).
// - irq_wu_ctrl_o: same as irq_req_ctrl_o without the mie term and without the FSM term.
// - irq_id/shv/level outputs always reflect cand_*_q.
// - FSM ARB->HOLD on irq_ack_i. HOLD->ARB unconditionally after 1 cycle.
//   In HOLD: irq_req_ctrl_o=0 and the cand regs still update, so the stale winner is never re-requested.
// - irq_ack_i while irq_req_ctrl_o=0 is illegal (assertion); ack id == irq_id_ctrl_o by definition.
// - mnxti_irq_pending_o = cand_vld_q & level > mpil & level > mintthresh & ~shv.
// - Simultaneous cfg write and arbitration: the write is visible to arbitration the next cycle.
// - Disabling the current winner (ie=0): request drops 2 cycles after the write edge.
// - Sync reset mid-HOLD or mid-request: all state cleared at that edge; no ack side effects survive.
// STRUCTURE
// - Package: typedef enum logic {CLIC_TRIG_LEVEL, CLIC_TRIG_EDGE} clic_trig_e;
//   typedef struct packed {ie, ip, clic_trig_e trig, shv, logic[7:0] level} clic_irq_cfg_t;
//   typedef enum logic {CLIC_ARB, CLIC_HOLD} clic_arb_state_e.
// - Sub-module cv32e40s_clic_max_tree: parametrised tournament comparator over {valid, level, id};
//   combinational output, registered by the parent.
// TESTING
// - Src 3 edge, ie=1, level=0x80, thresh=0, mie=1: pulse irq_i[3] at N -> req=1 id=3 at N+2;
//   ack -> ip[3]=0, req=0 for >=2 cycles.
// - Src 5 level=0x40 and src 9 level=0x40 pending: id=9. Then raise src 5 to 0x41: id=5 after 1 cycle.
// - Winner level 0x60, mintthresh=0x60, priv=M: req=0, wu=0; set priv=U: req=1.
// - CLIC_LEVEL_BITS=3, write level 0x00: readback 0x1F.
// - Level-trig src 7 held high, shv=1: ack -> 1-cycle HOLD gap, req reasserts id=7; mnxti_pending=0.
// - Assert rst during HOLD with pending edges: next cycle all outputs 0, all ip=0.

Source files
------------

// File: rtl/cv32e40s_clic_irq_arbiter_pkg.sv
// Shared types for the core-local CLIC arbiter: per-source configuration,
// arbiter FSM state and the CSR views it consumes.
package cv32e40s_clic_irq_arbiter_pkg;

    localparam int CLIC_LEVEL_W   = 8;
    localparam int IRQ_ID_CTRL_W  = 10;

    typedef enum logic {CLIC_TRIG_LEVEL, CLIC_TRIG_EDGE} clic_trig_e;

    typedef struct packed {
        logic                    ie;
        logic                    ip;
        clic_trig_e              trig;
        logic                    shv;
        logic [CLIC_LEVEL_W-1:0] level;
    } clic_irq_cfg_t;

    typedef enum logic {CLIC_ARB, CLIC_HOLD} clic_arb_state_e;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } privlvl_t;

    typedef struct packed {
        logic [1:0] mpp;
        logic       mpie;
        logic       mie;
    } mstatus_t;

    typedef struct packed {
        logic [7:0] mil;
        logic [7:0] sil;
        logic [7:0] uil;
    } mintstatus_t;

    typedef struct packed {
        logic        irq;
        logic        minhv;
        logic [1:0]  mpp;
        logic        mpie;
        logic [7:0]  mpil;
        logic [10:0] exception_code;
    } mcause_t;

    // Only the top 'bits' level bits are stored; the unimplemented LSBs read as ones.
    function automatic logic [CLIC_LEVEL_W-1:0] clic_level_fill(input logic [CLIC_LEVEL_W-1:0] level,
                                                                input int unsigned             bits);
        return level | (8'hFF >> bits);
    endfunction

endpackage

// File: rtl/cv32e40s_clic_irq_arbiter_max_tree.sv
// Tournament comparator picking the highest-level valid input; ties go to the higher id.
// Purely combinational; the parent registers the result.
module cv32e40s_clic_max_tree #(
    parameter int NUM_IN = 32,
    parameter int ID_W   = 5
) (
    input  logic [NUM_IN-1:0]           vld_i,
    input  logic [NUM_IN-1:0][7:0]      level_i,
    output logic                        vld_o,
    output logic [ID_W-1:0]             id_o,
    output logic [7:0]                  level_o
);

    localparam int LEAVES = 2 ** ID_W;
    localparam int NODES  = 2 * LEAVES - 1;

    logic [NODES-1:0]           node_vld;
    logic [NODES-1:0][7:0]      node_lvl;
    logic [NODES-1:0][ID_W-1:0] node_id;

    // Heap layout: node j has children 2j+1 (lower ids) and 2j+2 (higher ids),
    // so preferring the right child on equal level gives the higher id.
    always_comb begin
        node_vld = '0;
        node_lvl = '0;
        node_id  = '0;
        for (int i = 0; i < LEAVES; i++) begin
            node_id[LEAVES-1+i] = ID_W'(i);
        end
        for (int i = 0; i < NUM_IN; i++) begin
            node_vld[LEAVES-1+i] = vld_i[i];
            node_lvl[LEAVES-1+i] = vld_i[i] ? level_i[i] : 8'h00;
        end
        for (int j = LEAVES - 2; j >= 0; j--) begin
            if (node_vld[2*j+2] && (!node_vld[2*j+1] || (node_lvl[2*j+2] >= node_lvl[2*j+1]))) begin
                node_vld[j] = 1'b1;
                node_lvl[j] = node_lvl[2*j+2];
                node_id[j]  = node_id[2*j+2];
            end else begin
                node_vld[j] = node_vld[2*j+1];
                node_lvl[j] = node_lvl[2*j+1];
                node_id[j]  = node_id[2*j+1];
            end
        end
    end

    assign vld_o   = node_vld[0];
    assign id_o    = node_id[0];
    assign level_o = node_lvl[0];

endmodule

// File: rtl/cv32e40s_clic_irq_arbiter.sv
// Core-local CLIC: per-source cfg/pending state, level arbitration, threshold
// filtering and the take-handshake towards the core controller.
module cv32e40s_clic_irq_arbiter
    import cv32e40s_clic_irq_arbiter_pkg::*;
#(
    parameter int NUM_IRQ         = 32,
    parameter int SMCLIC_ID_WIDTH = 5,
    parameter int CLIC_LEVEL_BITS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_IRQ-1:0]         irq_i,
    input  logic                       cfg_we_i,
    input  logic [SMCLIC_ID_WIDTH-1:0] cfg_id_i,
    input  clic_irq_cfg_t              cfg_i,
    output clic_irq_cfg_t              cfg_o,
    input  logic                       irq_ack_i,
    input  mstatus_t                   mstatus_i,
    input  logic [7:0]                 mintthresh_i,
    input  mintstatus_t                mintstatus_i,
    input  mcause_t                    mcause_i,
    input  privlvl_t                   priv_lvl_i,
    output logic                       irq_req_ctrl_o,
    output logic [IRQ_ID_CTRL_W-1:0]   irq_id_ctrl_o,
    output logic                       irq_wu_ctrl_o,
    output logic                       irq_clic_shv_o,
    output logic [7:0]                 irq_clic_level_o,
    output logic                       mnxti_irq_pending_o,
    output logic [SMCLIC_ID_WIDTH-1:0] mnxti_irq_id_o,
    output logic [7:0]                 mnxti_irq_level_o
);

    localparam int ID_W = SMCLIC_ID_WIDTH;

    clic_irq_cfg_t              cfg_q [NUM_IRQ];
    clic_irq_cfg_t              cfg_d [NUM_IRQ];
    logic [NUM_IRQ-1:0]         irq_q;
    logic [NUM_IRQ-1:0]         edge_set;
    logic [NUM_IRQ-1:0]         wr_sel;
    logic [NUM_IRQ-1:0]         ack_sel;

    logic [NUM_IRQ-1:0]         leaf_vld;
    logic [NUM_IRQ-1:0][7:0]    leaf_level;

    logic                       cand_vld_d,   cand_vld_q;
    logic [ID_W-1:0]            cand_id_d,    cand_id_q;
    logic [7:0]                 cand_level_d, cand_level_q;
    logic                       cand_shv_d,   cand_shv_q;

    clic_arb_state_e            state_q;

    logic                       priv_m;
    logic [7:0]                 m_thresh;
    logic                       level_ok;
    logic                       unused_csr;

    assign edge_set = irq_i & ~irq_q;

    always_comb begin
        wr_sel  = '0;
        ack_sel = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            wr_sel[i]  = cfg_we_i  && (cfg_id_i  == ID_W'(i));
            ack_sel[i] = irq_ack_i && (cand_id_q == ID_W'(i));
        end
    end

    // Pending update order for edge sources: new edge beats a cfg write, which beats the ack clear.
    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++) begin
            cfg_d[i] = cfg_q[i];
            if (wr_sel[i]) begin
                cfg_d[i].ie    = cfg_i.ie;
                cfg_d[i].trig  = cfg_i.trig;
                cfg_d[i].shv   = cfg_i.shv;
                cfg_d[i].level = clic_level_fill(cfg_i.level, CLIC_LEVEL_BITS);
            end
            if (cfg_d[i].trig == CLIC_TRIG_LEVEL) begin
                cfg_d[i].ip = irq_i[i];
            end else if (edge_set[i]) begin
                cfg_d[i].ip = 1'b1;
            end else if (wr_sel[i]) begin
                cfg_d[i].ip = cfg_i.ip;
            end else if (ack_sel[i]) begin
                cfg_d[i].ip = 1'b0;
            end
        end
    end

    always_comb begin
        leaf_vld   = '0;
        leaf_level = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            leaf_vld[i]   = cfg_q[i].ie && cfg_q[i].ip && (cfg_q[i].level != 8'h00);
            leaf_level[i] = cfg_q[i].level;
        end
    end

    cv32e40s_clic_max_tree #(
        .NUM_IN (NUM_IRQ),
        .ID_W   (ID_W)
    ) u_max_tree (
        .vld_i   (leaf_vld),
        .level_i (leaf_level),
        .vld_o   (cand_vld_d),
        .id_o    (cand_id_d),
        .level_o (cand_level_d)
    );

    always_comb begin
        cfg_o      = '0;
        cand_shv_d = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (cfg_id_i == ID_W'(i)) begin
                cfg_o = cfg_q[i];
            end
            if (cand_vld_d && (cand_id_d == ID_W'(i))) begin
                cand_shv_d = cfg_q[i].shv;
            end
        end
    end

    // Candidate regs keep updating during HOLD so the taken winner is gone before ARB resumes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                cfg_q[i] <= '0;
            end
            irq_q        <= '0;
            cand_vld_q   <= 1'b0;
            cand_id_q    <= '0;
            cand_level_q <= '0;
            cand_shv_q   <= 1'b0;
            state_q      <= CLIC_ARB;
        end else begin
            cfg_q        <= cfg_d;
            irq_q        <= irq_i;
            cand_vld_q   <= cand_vld_d;
            cand_id_q    <= cand_id_d;
            cand_level_q <= cand_level_d;
            cand_shv_q   <= cand_shv_d;
            case (state_q)
                CLIC_ARB:  if (irq_ack_i) state_q <= CLIC_HOLD;
                CLIC_HOLD: state_q <= CLIC_ARB;
                default:   state_q <= CLIC_ARB;
            endcase
        end
    end

    assign priv_m   = (priv_lvl_i == PRIV_LVL_M);
    assign m_thresh = (mintstatus_i.mil > mintthresh_i) ? mintstatus_i.mil : mintthresh_i;
    assign level_ok = priv_m ? (cand_level_q > m_thresh) : (cand_level_q != 8'h00);

    assign irq_wu_ctrl_o    = cand_vld_q && level_ok;
    assign irq_req_ctrl_o   = irq_wu_ctrl_o && (state_q == CLIC_ARB) && (mstatus_i.mie || !priv_m);
    assign irq_id_ctrl_o    = IRQ_ID_CTRL_W'(cand_id_q);
    assign irq_clic_shv_o   = cand_shv_q;
    assign irq_clic_level_o = cand_level_q;

    assign mnxti_irq_pending_o = cand_vld_q && (cand_level_q > mcause_i.mpil) &&
                                 (cand_level_q > mintthresh_i) && !cand_shv_q;
    assign mnxti_irq_id_o      = cand_id_q;
    assign mnxti_irq_level_o   = cand_level_q;

    assign unused_csr = ^{mstatus_i.mpp, mstatus_i.mpie, mintstatus_i.sil, mintstatus_i.uil,
                          mcause_i.irq, mcause_i.minhv, mcause_i.mpp, mcause_i.mpie,
                          mcause_i.exception_code};

    ack_needs_req: assert property (@(posedge clk) disable iff (rst) irq_ack_i |-> irq_req_ctrl_o);

endmodule
